div_issue_ctrl: RTL

Upstream issue/collect stage for the team's combinational unsigned divider (`div`, WIDTH-bit, outputs quotient and dbz).
- Accepts operand pairs over a valid/ready interface and buffers them in a small FIFO.
- Presents one pair at a time, from registers, on the divider inputs and holds it for a programmable settle time.
- Captures the quotient and dbz flag, then returns them over a valid/ready result interface.
- Keeps a saturating divide-by-zero event count.

---
 rtl/div_issue_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl
// Issue/collect stage in front of a combinational unsigned divider.
// Operand pairs are queued in a small FIFO. Each pair is placed on the
// divider inputs from registers and held there for SETTLE cycles. The
// quotient and divide-by-zero flag are then captured and returned over a
// valid/ready result interface.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   in_valid/in_ready                operand handshake
//   in_dividend/in_divisor           operand pair (WIDTH bits each)
//   div_in1/div_in2                  registered operands to the divider
//   div_out/div_dbz                  divider quotient and divide-by-zero flag
//   res_valid/res_ready              result handshake
//   res_quot/res_dbz                 captured quotient and dbz flag
//   dbz_count                        saturating count of accepted dbz results
//   busy                             FSM active or FIFO non-empty
module div_issue_ctrl #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,   // power of two, >= 2
  parameter int SETTLE = 1    // >= 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  output logic [WIDTH-1:0] div_in1,
  output logic [WIDTH-1:0] div_in2,
  input  logic [WIDTH-1:0] div_out,
  input  logic             div_dbz,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_quot,
  output logic             res_dbz,
  output logic [7:0]       dbz_count,
  output logic             busy
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int SET_W = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [SET_W-1:0] r_settle;
  logic [WIDTH-1:0] r_mem_dividend [DEPTH];
  logic [WIDTH-1:0] r_mem_divisor  [DEPTH];
  logic [WIDTH-1:0] r_div_in1;
  logic [WIDTH-1:0] r_div_in2;
  logic             r_res_valid;
  logic [WIDTH-1:0] r_res_quot;
  logic             r_res_dbz;
  logic [7:0]       r_dbz_count;

  logic w_in_ready;
  logic w_push;
  logic w_pop;

  // Full is judged from the registered count only, so a pop in the same
  // cycle does not reopen the input until the next cycle.
  assign w_in_ready = (r_count != CNT_W'(DEPTH));
  assign w_push     = in_valid && w_in_ready;
  assign w_pop      = (r_state == IDLE) && (r_count != '0);

  // NOTE: the FIFO storage has no reset; only pointers and count define
  // which entries are valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_dividend[r_wr_ptr] <= in_dividend;
      r_mem_divisor[r_wr_ptr]  <= in_divisor;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_settle    <= '0;
      r_div_in1   <= '0;
      r_div_in2   <= '0;
      r_res_valid <= 1'b0;
      r_res_quot  <= '0;
      r_res_dbz   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_div_in1 <= r_mem_dividend[r_rd_ptr];
            r_div_in2 <= r_mem_divisor[r_rd_ptr];
            r_settle  <= '0;
            r_state   <= ISSUE;
          end
        end
        ISSUE: begin
          r_settle <= r_settle + 1'b1;
          // Operands have been stable for SETTLE cycles at this edge.
          if (r_settle == SET_W'(SETTLE - 1)) begin
            r_res_quot  <= div_out;
            r_res_dbz   <= div_dbz;
            r_res_valid <= 1'b1;
            r_state     <= HOLD;
          end
        end
        HOLD: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dbz_count <= '0;
    end else if (r_res_valid && res_ready && r_res_dbz && (r_dbz_count != 8'hFF)) begin
      r_dbz_count <= r_dbz_count + 1'b1;
    end
  end

  assign in_ready  = w_in_ready;
  assign div_in1   = r_div_in1;
  assign div_in2   = r_div_in2;
  assign res_valid = r_res_valid;
  assign res_quot  = r_res_quot;
  assign res_dbz   = r_res_dbz;
  assign dbz_count = r_dbz_count;
  assign busy      = (r_state != IDLE) || (r_count != '0);

endmodule
